mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified memory port between instruction fetch (IF/icache) and data (LSQ/dcache) requesters.
//  Picks one requester per cycle and drives the memory command combinationally.
//  Records the owner of each outstanding load tag, so returned data reaches the requester that issued the load.
//  Prevents fetch starvation with a bounded data-priority counter.
// PARAMETERS
//  STARVE_LIMIT  default 4   consecutive cycles fetch may lose to data before fetch is forced to win
//  NUM_TAGS      default 16  memory tag space; tag 0 = rejected / no tag
// PORTS
//  clock            in   1      clock
//  reset            in   1      synchronous, active-high
//  if_req_valid     in   1      fetch load request
//  if_req_addr      in   `XLEN  fetch address, 8B-aligned
//  if_req_ack       out  1      fetch request accepted by memory this cycle
//  if_req_tag       out  4      tag returned for the accepted fetch
//  if_rsp_valid     out  1      fetch data returning this cycle
//  if_rsp_tag       out  4      tag of the returning fetch data
//  if_rsp_data      out  64     fetch data
//  d_req_valid      in   1      data request
//  d_req_cmd        in   2      BUS_LOAD / BUS_STORE
//  d_req_addr       in   `XLEN  data address
//  d_req_wdata      in   64     store data
//  d_req_ack        out  1      data request accepted this cycle
//  d_req_tag        out  4      tag for the accepted data load (0 for a store)
//  d_rsp_valid      out  1      data load returning this cycle
//  d_rsp_tag        out  4      tag of the returning data load
//  d_rsp_data       out  64     data load data
//  proc2mem_command out  2      BUS_NONE / BUS_LOAD / BUS_STORE
//  proc2mem_addr    out  `XLEN  memory address
//  proc2mem_data    out  64     store data
//  mem2proc_response in  4      nonzero = accepted; value = tag
//  mem2proc_data    in   64     returned load data
//  mem2proc_tag     in   4      nonzero = tag of data returning this cycle
// BEHAVIOUR
//  - Priority FSM: PRIO_D (reset state) and PRIO_I.
//    - PRIO_D: a valid data request wins; otherwise fetch wins.
//    - PRIO_I: fetch wins if valid; otherwise data wins.
//  - Starve counter (clog2(STARVE_LIMIT+1) bits):
//    - Increments on each cycle the arbiter selects data while if_req_valid is 1.
//    - Clears on a fetch ack and on reset.
//    - Reaching STARVE_LIMIT moves the FSM to PRIO_I.
//    - A fetch ack returns the FSM to PRIO_D and clears the counter.
//    - A memory rejection (response == 0) changes neither the counter nor the FSM.
//  - Command path is combinational, zero latency. Only the selected requester's fields drive proc2mem_*.
//    - proc2mem_command = BUS_NONE when neither request is valid.
//  - Ack/tag:
//    - Winner's ack = (mem2proc_response != 0); winner's tag = mem2proc_response.
//    - Loser's ack = 0, tag = 0.
//    - Store ack sets d_req_tag = 0 and allocates no owner entry.
//  - Owner table: NUM_TAGS entries of {valid, owner(0 = IF, 1 = D)}.
//    - An accepted load writes entry[response] at the clock edge.
//  - Return routing:
//    - mem2proc_tag != 0 with a valid entry: assert the owner's rsp_valid, copy the tag and data, clear the entry at the edge.
//    - mem2proc_tag != 0 with no valid entry (orphan): drop it; no rsp_valid.
//    - Return and new allocation of the same tag in one cycle: the return is routed from the old owner, then the entry holds the new owner.
//    - Both rsp_valid outputs are never 1 in the same cycle.
//  - Reset (sync; also mid-transaction):
//    - FSM = PRIO_D, counter = 0, all owner entries invalid.
//    - While reset is high: proc2mem_command = BUS_NONE; all ack/rsp_valid = 0; all tags = 0; all data outputs = 0.
//    - Data returning after reset for tags issued before it is an orphan and is dropped.
// CONFIGURATION
//  MEM_ARB_DEBUG_EN defined:
//    - Adds outputs dbg_orphan_err (1, sticky until reset), dbg_if_grants (32) and dbg_d_grants (32).
//    - Grant counters count acks and wrap at 2^32.
//  Undefined: those ports and all their logic are absent; behaviour is otherwise identical.
// TESTING
//  1. Reset, no requests -> proc2mem_command = BUS_NONE, all acks 0, FSM = PRIO_D.
//  2. Fetch only, addr 0x100, response 3 -> if_req_ack = 1, tag 3.
//     Later mem2proc_tag = 3, data 0xDEAD -> if_rsp_valid = 1, if_rsp_data = 0xDEAD, d_rsp_valid = 0.
//  3. Both requests held valid every cycle, response always nonzero, STARVE_LIMIT = 4
//     -> 4 data acks, then 1 fetch ack, then data again.
//  4. Data store with response 5 -> d_req_ack = 1, d_req_tag = 0.
//     mem2proc_tag = 5 afterwards -> no rsp_valid (orphan); dbg_orphan_err = 1 with MEM_ARB_DEBUG_EN.
//  5. Same cycle: tag 7 returns to IF while a new data load is accepted with response 7
//     -> if_rsp_valid = 1 this cycle; next return of tag 7 goes to d_rsp.
//  6. Reset asserted with 3 loads outstanding; their tags return afterwards -> all dropped, no rsp_valid.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single unified memory port between instruction fetch
// and data requesters.
//
// One requester is chosen each cycle and its command is driven to memory
// combinationally (zero latency). The tag that memory hands back for an
// accepted load is recorded with its owner, so returning data is routed to
// the requester that issued the load. A bounded counter keeps a steady stream
// of data traffic from starving fetch.
//
// Ports
//   clock, reset                    clock; synchronous active-high reset
//   if_req_valid/addr               fetch load request
//   if_req_ack/tag                  fetch accepted this cycle, with its tag
//   if_rsp_valid/tag/data           fetch data returning
//   d_req_valid/cmd/addr/wdata      data request (BUS_LOAD / BUS_STORE)
//   d_req_ack/tag                   data accepted (tag 0 for a store)
//   d_rsp_valid/tag/data            data load returning
//   proc2mem_command/addr/data      memory command port
//   mem2proc_response               nonzero = accepted, value = tag
//   mem2proc_data/tag               returning load data and its tag
//
// Optional feature macro: MEM_ARB_DEBUG_EN adds dbg_orphan_err (sticky until
// reset), dbg_if_grants and dbg_d_grants (ack counters, wrap at 2^32).
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               if_req_valid,
    input  logic [`XLEN-1:0]   if_req_addr,
    output logic               if_req_ack,
    output logic [3:0]         if_req_tag,
    output logic               if_rsp_valid,
    output logic [3:0]         if_rsp_tag,
    output logic [63:0]        if_rsp_data,
    input  logic               d_req_valid,
    input  logic [1:0]         d_req_cmd,
    input  logic [`XLEN-1:0]   d_req_addr,
    input  logic [63:0]        d_req_wdata,
    output logic               d_req_ack,
    output logic [3:0]         d_req_tag,
    output logic               d_rsp_valid,
    output logic [3:0]         d_rsp_tag,
    output logic [63:0]        d_rsp_data,
    output logic [1:0]         proc2mem_command,
    output logic [`XLEN-1:0]   proc2mem_addr,
    output logic [63:0]        proc2mem_data,
    input  logic [3:0]         mem2proc_response,
    input  logic [63:0]        mem2proc_data,
    input  logic [3:0]         mem2proc_tag
`ifdef MEM_ARB_DEBUG_EN
    ,
    output logic               dbg_orphan_err,
    output logic [31:0]        dbg_if_grants,
    output logic [31:0]        dbg_d_grants
`endif
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int         CNT_W     = $clog2(STARVE_LIMIT + 1);

    typedef enum logic { PRIO_D = 1'b0, PRIO_I = 1'b1 } prio_e;

    prio_e              state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [NUM_TAGS-1:0] own_vld_q;
    logic [NUM_TAGS-1:0] own_d_q;      // owner bit: 0 = fetch, 1 = data

    logic sel_if, sel_d, accepted, d_is_load, alloc;
    logic ret_hit, ret_owner_d;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= PRIO_D;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // ---------------- FSM next state ----------------
    // Only accepted grants move the counter; a memory rejection leaves both
    // the counter and the priority untouched.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (if_req_ack) begin
            state_d  = PRIO_D;
            starve_d = '0;
        end else if (d_req_ack && if_req_valid) begin
            if (starve_q < CNT_W'(STARVE_LIMIT))
                starve_d = starve_q + 1'b1;
            if (starve_d == CNT_W'(STARVE_LIMIT))
                state_d = PRIO_I;
        end
    end

    // ---------------- FSM outputs: requester selection ----------------
    always_comb begin
        sel_if = 1'b0;
        sel_d  = 1'b0;
        if (!reset) begin
            if (state_q == PRIO_D) begin
                sel_d  = d_req_valid;
                sel_if = if_req_valid && !d_req_valid;
            end else begin
                sel_if = if_req_valid;
                sel_d  = d_req_valid && !if_req_valid;
            end
        end
    end

    assign accepted  = (mem2proc_response != 4'd0);
    assign d_is_load = (d_req_cmd == BUS_LOAD);

    // Command path and ack/tag
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (sel_if) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = if_req_addr;
        end else if (sel_d) begin
            proc2mem_command = d_req_cmd;
            proc2mem_addr    = d_req_addr;
            proc2mem_data    = d_req_wdata;
        end
    end

    assign if_req_ack = sel_if && accepted;
    assign d_req_ack  = sel_d && accepted;
    assign if_req_tag = if_req_ack ? mem2proc_response : 4'd0;
    assign d_req_tag  = (d_req_ack && d_is_load) ? mem2proc_response : 4'd0;
    assign alloc      = if_req_ack || (d_req_ack && d_is_load);

    // Return routing reads the table before this edge's update, so a return
    // and a re-allocation of the same tag route to the previous owner.
    assign ret_hit     = !reset && (mem2proc_tag != 4'd0) && own_vld_q[mem2proc_tag];
    assign ret_owner_d = own_d_q[mem2proc_tag];

    assign if_rsp_valid = ret_hit && !ret_owner_d;
    assign d_rsp_valid  = ret_hit && ret_owner_d;
    assign if_rsp_tag   = if_rsp_valid ? mem2proc_tag  : 4'd0;
    assign if_rsp_data  = if_rsp_valid ? mem2proc_data : 64'd0;
    assign d_rsp_tag    = d_rsp_valid  ? mem2proc_tag  : 4'd0;
    assign d_rsp_data   = d_rsp_valid  ? mem2proc_data : 64'd0;

    // Owner table: clear on return first, then a new allocation wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            own_vld_q <= '0;
        end else begin
            if (ret_hit)
                own_vld_q[mem2proc_tag] <= 1'b0;
            if (alloc)
                own_vld_q[mem2proc_response] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (alloc)
            own_d_q[mem2proc_response] <= d_req_ack;
    end

`ifdef MEM_ARB_DEBUG_EN
    logic        orphan_q;
    logic [31:0] if_grants_q, d_grants_q;
    logic        ret_orphan;

    assign ret_orphan = !reset && (mem2proc_tag != 4'd0) && !own_vld_q[mem2proc_tag];

    always_ff @(posedge clock) begin
        if (reset) begin
            orphan_q    <= 1'b0;
            if_grants_q <= '0;
            d_grants_q  <= '0;
        end else begin
            if (ret_orphan)
                orphan_q <= 1'b1;
            if (if_req_ack)
                if_grants_q <= if_grants_q + 32'd1;
            if (d_req_ack)
                d_grants_q <= d_grants_q + 32'd1;
        end
    end

    assign dbg_orphan_err = orphan_q;
    assign dbg_if_grants  = if_grants_q;
    assign dbg_d_grants   = d_grants_q;
`endif

endmodule
